// File: rtl/credit_tx.sv
// Transmitter end of a credit-flow link: forwards accepted items one cycle later
// and tracks free slots in the remote queue so the link never needs a ready.
module credit_tx #(
  parameter type Data          = logic [31:0],
  parameter int  DEPTH         = 2,
  parameter bit  BYPASS_CREDIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  Data                        enq_data,
  input  logic                       flush,
  input  logic                       credit_ret,
  output logic                       tx_valid,
  output Data                        tx_data,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       idle,
  output logic                       credit_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] credits_r;
  logic [CW-1:0] credits_next_s;
  logic          tx_valid_r;
  logic          tx_valid_next_s;
  Data           tx_data_r;
  Data           tx_data_next_s;
  logic          credit_err_r;
  logic          credit_err_next_s;
  logic          idle_r;
  logic          idle_next_s;
  logic          fire_s;
  logic          ready_s;

  // Ready depends only on registered credits plus flush/credit_ret, never on valid.
  always_comb begin
    ready_s = 1'b0;
    if (flush) begin
      ready_s = 1'b0;
    end else if (BYPASS_CREDIT) begin
      ready_s = (credits_r != ZERO) || credit_ret;
    end else begin
      ready_s = (credits_r != ZERO);
    end
    fire_s = enq_valid && ready_s;
  end

  // Next-state for credits, link register and sticky over-return flag.
  always_comb begin
    credits_next_s    = credits_r;
    tx_valid_next_s   = 1'b0;
    tx_data_next_s    = tx_data_r;
    credit_err_next_s = credit_err_r;
    if (flush) begin
      // Remote queue flushes in the same cycle; any returned credit is moot.
      credits_next_s  = FULL;
      tx_valid_next_s = 1'b0;
    end else begin
      if (fire_s) begin
        tx_valid_next_s = 1'b1;
        tx_data_next_s  = enq_data;
      end else begin
        tx_valid_next_s = 1'b0;
      end
      case ({fire_s, credit_ret})
        2'b10:   credits_next_s = credits_r - ONE;
        2'b01: begin
          if (credits_r == FULL) begin
            credits_next_s    = FULL;
            credit_err_next_s = 1'b1;
          end else begin
            credits_next_s = credits_r + ONE;
          end
        end
        default: credits_next_s = credits_r;
      endcase
    end
    idle_next_s = (credits_next_s == FULL) && !tx_valid_next_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r    <= FULL;
      tx_valid_r   <= 1'b0;
      tx_data_r    <= '0;
      credit_err_r <= 1'b0;
      idle_r       <= 1'b1;
    end else begin
      credits_r    <= credits_next_s;
      tx_valid_r   <= tx_valid_next_s;
      tx_data_r    <= tx_data_next_s;
      credit_err_r <= credit_err_next_s;
      idle_r       <= idle_next_s;
    end
  end

  assign enq_ready  = ready_s;
  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;
  assign credits    = credits_r;
  assign credit_err = credit_err_r;
  assign idle       = idle_r;

endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx: two instances (no bypass / bypass), a credit-count model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_credit_tx;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rs [2];
  logic        ev [2];
  logic [31:0] ed [2];
  logic        fl [2];
  logic        cr [2];
  logic        rdy[2];
  logic        txv[2];
  logic [31:0] txd[2];
  logic [1:0]  crd[2];
  logic        idl[2];
  logic        err[2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit byp [2] = '{1'b0, 1'b1};

  // Model state
  int          m_cred[2];
  bit          m_txv [2];
  logic [31:0] m_txd [2];
  bit          m_err [2];
  int          m_sent[2];
  int          m_ret [2];

  always #5 clk = ~clk;

  credit_tx #(.Data(logic [31:0]), .DEPTH(DEPTH), .BYPASS_CREDIT(1'b0)) u0 (
    .clk(clk), .rst(rs[0]), .enq_valid(ev[0]), .enq_ready(rdy[0]), .enq_data(ed[0]),
    .flush(fl[0]), .credit_ret(cr[0]), .tx_valid(txv[0]), .tx_data(txd[0]),
    .credits(crd[0]), .idle(idl[0]), .credit_err(err[0]));

  credit_tx #(.Data(logic [31:0]), .DEPTH(DEPTH), .BYPASS_CREDIT(1'b1)) u1 (
    .clk(clk), .rst(rs[1]), .enq_valid(ev[1]), .enq_ready(rdy[1]), .enq_data(ed[1]),
    .flush(fl[1]), .credit_ret(cr[1]), .tx_valid(txv[1]), .tx_data(txd[1]),
    .credits(crd[1]), .idle(idl[1]), .credit_err(err[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready(input int i);
    return !fl[i] && (m_cred[i] != 0 || (byp[i] && cr[i]));
  endfunction

  // Model: credits are free remote slots; sent and returned items move them.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        m_cred[i] = DEPTH; m_txv[i] = 0; m_txd[i] = '0; m_err[i] = 0;
        m_sent[i] = 0; m_ret[i] = 0;
      end else if (fl[i]) begin
        m_cred[i] = DEPTH; m_txv[i] = 0; m_sent[i] = 0; m_ret[i] = 0;
      end else begin
        bit f;
        f = ev[i] && m_ready(i);
        m_txv[i] = f;
        if (f) begin
          m_txd[i] = ed[i];
          m_sent[i]++;
        end
        if (cr[i] && !f && m_cred[i] == DEPTH) m_err[i] = 1;
        else if (cr[i]) m_ret[i]++;
        m_cred[i] = m_cred[i] - int'(f) + int'(cr[i]);
        if (m_cred[i] > DEPTH) m_cred[i] = DEPTH;
      end
    end
  end

  // Compare all outputs against the model every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_ready", i), 32'(rdy[i]), 32'(m_ready(i)));
        chk($sformatf("u%0d_tx_valid", i), 32'(txv[i]), 32'(m_txv[i]));
        chk($sformatf("u%0d_tx_data", i), txd[i], m_txd[i]);
        chk($sformatf("u%0d_credits", i), 32'(crd[i]), 32'(m_cred[i]));
        chk($sformatf("u%0d_idle", i), 32'(idl[i]), 32'(m_cred[i] == DEPTH && !m_txv[i]));
        chk($sformatf("u%0d_credit_err", i), 32'(err[i]), 32'(m_err[i]));
        chk($sformatf("u%0d_balance", i), 32'(m_sent[i] - m_ret[i]), 32'(DEPTH - int'(crd[i])));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rs[i] = 1'b1; ev[i] = 1'b0; ed[i] = '0; fl[i] = 1'b0; cr[i] = 1'b0;
    end
    step();
    rs[0] = 1'b0; rs[1] = 1'b0;
    chk_en = 1'b1;
    chk("reset_credits", 32'(crd[0]), 32'd2);
    chk("reset_idle", 32'(idl[0]), 32'd1);
    chk("reset_tx_valid", 32'(txv[0]), 32'd0);
    chk("reset_tx_data", txd[0], 32'h0);

    // Hold valid for 4 cycles with no credit return: only two fires.
    ev[0] = 1'b1;
    ed[0] = 32'hA0; #1 chk("fill_ready0", 32'(rdy[0]), 32'd1); step();
    chk("fill_tx0", txd[0], 32'hA0);
    ed[0] = 32'hA1; step();
    chk("fill_tx1_valid", 32'(txv[0]), 32'd1);
    chk("fill_tx1", txd[0], 32'hA1);
    chk("fill_credits0", 32'(crd[0]), 32'd0);
    ed[0] = 32'hA2; #1 chk("fill_ready_low", 32'(rdy[0]), 32'd0); step();
    chk("fill_tx_drop", 32'(txv[0]), 32'd0);
    ed[0] = 32'hA3; step();
    ev[0] = 1'b0;

    // One credit back re-opens ready; the next fire spends it.
    cr[0] = 1'b1; step(); cr[0] = 1'b0;
    chk("ret_credits1", 32'(crd[0]), 32'd1);
    #1 chk("ret_ready", 32'(rdy[0]), 32'd1);
    ev[0] = 1'b1; ed[0] = 32'hE5; step(); ev[0] = 1'b0;
    chk("ret_spend_credits", 32'(crd[0]), 32'd0);
    chk("ret_spend_data", txd[0], 32'hE5);

    // Simultaneous fire and return at credits=1.
    cr[0] = 1'b1; step();
    ev[0] = 1'b1; ed[0] = 32'hF6; step(); ev[0] = 1'b0; cr[0] = 1'b0;
    chk("both_credits", 32'(crd[0]), 32'd1);
    chk("both_data", txd[0], 32'hF6);

    // Random interleaving; the balance check runs every cycle.
    for (int k = 0; k < 20; k++) begin
      ev[0] = 1'($urandom_range(0, 1));
      ed[0] = $urandom;
      cr[0] = (m_cred[0] < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    ev[0] = 1'b0;
    for (int k = 0; k < 8 && m_cred[0] < DEPTH; k++) begin
      cr[0] = 1'b1; step();
    end
    cr[0] = 1'b0; step();
    chk("drain_idle", 32'(idl[0]), 32'd1);

    // Over-return is sticky through flush, cleared by reset.
    cr[0] = 1'b1; step(); cr[0] = 1'b0;
    chk("over_err", 32'(err[0]), 32'd1);
    chk("over_credits", 32'(crd[0]), 32'd2);
    fl[0] = 1'b1; step(); fl[0] = 1'b0;
    chk("over_flush_err", 32'(err[0]), 32'd1);
    rs[0] = 1'b1; step(); rs[0] = 1'b0;
    chk("over_rst_err", 32'(err[0]), 32'd0);

    // Flush at credits=0 with tx busy blocks the enq and ignores the return.
    ev[0] = 1'b1; ed[0] = 32'h11; step(); ed[0] = 32'h12; step();
    cr[0] = 1'b1; fl[0] = 1'b1; ed[0] = 32'h13;
    #1 chk("flush_ready", 32'(rdy[0]), 32'd0);
    step();
    ev[0] = 1'b0; cr[0] = 1'b0; fl[0] = 1'b0;
    chk("flush_credits", 32'(crd[0]), 32'd2);
    chk("flush_tx_valid", 32'(txv[0]), 32'd0);
    chk("flush_err", 32'(err[0]), 32'd0);

    // Bypass instance: credit returned at zero is spent in the same cycle.
    ev[1] = 1'b1; ed[1] = 32'hB0; step(); ed[1] = 32'hB1; step();
    chk("byp_credits0", 32'(crd[1]), 32'd0);
    cr[1] = 1'b1; ed[1] = 32'hB2;
    #1 chk("byp_ready", 32'(rdy[1]), 32'd1);
    step();
    ev[1] = 1'b0; cr[1] = 1'b0;
    chk("byp_credits", 32'(crd[1]), 32'd0);
    chk("byp_tx_valid", 32'(txv[1]), 32'd1);
    chk("byp_tx_data", txd[1], 32'hB2);
    step();
    chk("byp_tx_done", 32'(txv[1]), 32'd0);
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmitter end of a credit-flow link. The receiving end is a `queue` of depth DEPTH on the far side of a registered link.
- Accepts items on a decoupled input and forwards each one across the link exactly one cycle later.
- Holds a credit counter that mirrors the free slots in the remote queue. It never sends an item the remote queue cannot accept, so the link itself needs no ready signal.
- Sits at unit boundaries where a combinational ready cannot cross, e.g. issue to a remote reservation-station queue.

Parameters:
- Data, gpreg: payload type carried on enq and tx_data.
- DEPTH, 2: number of entries in the remote queue; also the reset and flush value of the credit counter. Must be ≥ 1.
- BYPASS_CREDIT, 0: when 1, a credit returned in a cycle may be spent in that same cycle.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- enq  decoupled.in  Data  upstream items; ready driven by this block.
- flush  input  1  pipeline flush; the remote queue is flushed in the same cycle.
- credit_ret  input  1  one-cycle pulse; the remote queue freed one slot (its deq fired).
- tx_valid  output  1  link item valid, registered.
- tx_data  output  $bits(Data)  link payload, registered.
- credits  output  $clog2(DEPTH+1)  current credit count.
- idle  output  1  no items in flight: credits == DEPTH && !tx_valid.
- credit_err  output  1  sticky flag: a credit was returned while the counter was already full.

Behaviour:
- Reset (rst high at a posedge), all registers:
  - credits = DEPTH
  - tx_valid = 0
  - tx_data = '0
  - credit_err = 0
  - idle therefore reads 1.
- Ready:
  - BYPASS_CREDIT=0: enq.ready = !flush && credits != 0.
  - BYPASS_CREDIT=1: enq.ready = !flush && (credits != 0 || credit_ret).
  - Ready is combinational from registered state and the flush/credit_ret inputs only; it never depends on enq.valid.
- fire = enq.valid && enq.ready.
- Transmit, latency exactly 1 cycle:
  - On a posedge with fire: tx_valid <= 1 and tx_data <= enq.data.
  - Otherwise: tx_valid <= 0 and tx_data holds its previous value.
  - No backpressure on tx; tx_valid lasts exactly one cycle per accepted item.
  - Back-to-back fires produce back-to-back tx_valid cycles.
- Credit update (non-flush cycle):
  - credits_next = credits - fire + credit_ret.
  - fire and credit_ret in the same cycle: credits unchanged.
  - With BYPASS_CREDIT=1 at credits == 0 with credit_ret: fire is allowed and credits stays 0.
- Over-return: credit_ret && !fire && credits == DEPTH:
  - credits saturates at DEPTH (no wrap).
  - credit_err <= 1.
- Underflow cannot occur: ready gating prevents fire at credits == 0 without a bypass credit.
- Flush (takes priority over fire and credit_ret):
  - credits <= DEPTH, tx_valid <= 0.
  - enq.ready = 0 in the flush cycle, so no item is accepted.
  - credit_ret in the flush cycle is ignored and does not set credit_err.
  - An item already on tx (tx_valid=1 in the flush cycle) is discarded by the receiver's own flush.
- credit_err:
  - Cleared only by rst; not cleared by flush.
  - Once set, it stays high regardless of later credit traffic.
- Widths:
  - credits is $clog2(DEPTH+1) bits, so DEPTH itself is representable.
  - Arithmetic is unsigned, with no modular wrap permitted.
- Reset mid-operation: in-flight tx_valid is dropped and credits restored to DEPTH; the same behaviour as flush plus clearing credit_err.

Test Plan:
- DEPTH=2, BYPASS=0, enq.valid held high for 4 cycles, no credit_ret:
  - Exactly 2 fires in the first 2 cycles.
  - tx_valid high in cycles 2 and 3 with the matching data.
  - Then credits=0 and enq.ready=0.
- From credits=0, pulse credit_ret once:
  - credits=1 next cycle and enq.ready goes high.
  - The next fire drops credits to 0; tx_data equals that enq.data.
- BYPASS=1, credits=0, credit_ret and enq.valid in the same cycle:
  - enq.ready=1 and fire occurs.
  - credits stays 0; tx_valid=1 the next cycle.
- credits=1, fire and credit_ret in the same cycle:
  - credits stays 1.
  - Over 20 random interleaved cycles, sent minus returned always equals DEPTH - credits.
- Idle block (credits=DEPTH), pulse credit_ret:
  - credit_err=1 and credits stays DEPTH.
  - A following flush leaves credit_err=1; rst clears it.
- credits=0 and tx_valid=1, assert flush with enq.valid=1 and credit_ret=1:
  - enq.ready=0 in that cycle.
  - Next cycle: credits=DEPTH, tx_valid=0, credit_err unchanged.
